// File: rtl/disp_collect_320_if.sv
// Output stream of disp_collect_320: valid/ready word plus line and frame markers.
interface disp_collect_320_if #(
  parameter int DISP_WIDTH = 7
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DISP_WIDTH-1:0] out_disp;
  logic                  out_conf;
  logic                  out_sol;
  logic                  out_eol;
  logic                  out_sof;
  logic                  out_eof;

  modport master (
    output out_valid, out_disp, out_conf,
    output out_sol, out_eol, out_sof, out_eof,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_disp, out_conf,
    input  out_sol, out_eol, out_sof, out_eof,
    output out_ready
  );
endinterface

// File: rtl/disp_collect_320.sv
// Tags argmin-tree results with position/confidence and buffers them for output.
// Optional frame bad-pixel statistics are enabled with macro DISP_STATS_EN.
module disp_collect_320 #(
  parameter int COST_WIDTH = 7,
  parameter int DISP_WIDTH = 7,
  parameter int NUM_DISP   = 80,
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int PIPE_LAT   = 7,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  argmin_en,
  input  logic [COST_WIDTH-1:0] cost,
  input  logic [DISP_WIDTH-1:0] disp,
  input  logic [COST_WIDTH-1:0] cfg_thresh,
  disp_collect_320_if.master    out
`ifdef DISP_STATS_EN
  ,
  output logic [$clog2(IMG_WIDTH*IMG_HEIGHT+1)-1:0] stat_bad_cnt,
  output logic                                      stat_strobe
`endif
);

  localparam int CNTW = $clog2(FIFO_DEPTH + 1);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int COLW = $clog2(IMG_WIDTH);
  localparam int ROWW = $clog2(IMG_HEIGHT);

  typedef struct packed {
    logic [DISP_WIDTH-1:0] d;
    logic                  conf;
    logic                  sol;
    logic                  eol;
    logic                  sof;
    logic                  eof;
  } word_t;

  logic [PIPE_LAT-1:0] vld_q;
  logic [COLW-1:0]     col_q;
  logic [ROWW-1:0]     row_q;
  logic [PW-1:0]       wr_q;
  logic [PW-1:0]       rd_q;
  logic [CNTW-1:0]     cnt_q;
  word_t               mem_q [FIFO_DEPTH];

  logic  push;
  logic  pop;
  logic  col_last;
  logic  row_last;
  logic  head_vld;
  word_t word_d;
  word_t head;

  // en only depends on the registered count, never on out_ready
  assign argmin_en = (cnt_q != CNTW'(FIFO_DEPTH));
  assign head_vld  = (cnt_q != '0);
  assign push      = argmin_en & vld_q[PIPE_LAT-1];
  assign pop       = head_vld & out.out_ready;
  assign col_last  = (col_q == COLW'(IMG_WIDTH - 1));
  assign row_last  = (row_q == ROWW'(IMG_HEIGHT - 1));

  always_comb begin
    word_d      = '0;
    word_d.conf = (cost <= cfg_thresh) &&
                  (col_q >= COLW'(NUM_DISP - 1));
    word_d.d    = word_d.conf ? disp : '0;
    word_d.sol  = (col_q == '0);
    word_d.eol  = col_last;
    word_d.sof  = (col_q == '0) && (row_q == '0);
    word_d.eof  = col_last && row_last;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      col_q <= '0;
      row_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (argmin_en) begin
        vld_q <= {vld_q[PIPE_LAT-2:0], in_valid};
      end
      if (push) begin
        wr_q <= wr_q + 1'b1;
        if (col_last) begin
          col_q <= '0;
          row_q <= row_last ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
      if (pop) begin
        rd_q <= rd_q + 1'b1;
      end
      cnt_q <= cnt_q + CNTW'(push) - CNTW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= word_d;
    end
  end

  // head word is gated so an empty FIFO presents all zeros
  assign head          = head_vld ? mem_q[rd_q] : '0;
  assign out.out_valid = head_vld;
  assign out.out_disp  = head.d;
  assign out.out_conf  = head.conf;
  assign out.out_sol   = head.sol;
  assign out.out_eol   = head.eol;
  assign out.out_sof   = head.sof;
  assign out.out_eof   = head.eof;

`ifdef DISP_STATS_EN
  localparam int SW = $clog2(IMG_WIDTH*IMG_HEIGHT+1);

  logic [SW-1:0] bad_q;
  logic [SW-1:0] bad_d;
  logic [SW-1:0] stat_q;
  logic          strobe_q;

  assign bad_d = bad_q + SW'(!word_d.conf);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bad_q    <= '0;
      stat_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (push) begin
        if (word_d.eof) begin
          stat_q   <= bad_d;
          strobe_q <= 1'b1;
          bad_q    <= '0;
        end else begin
          bad_q <= bad_d;
        end
      end
    end
  end

  assign stat_bad_cnt = stat_q;
  assign stat_strobe  = strobe_q;
`endif

endmodule

// File: tb/tb_disp_collect_320.sv
// Scoreboard bench for disp_collect_320 with a behavioural argmin-tree delay line.
module tb_disp_collect_320;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       argmin_en;
  logic [6:0] cost;
  logic [6:0] disp;
  logic [6:0] cfg_thresh = 7'd20;

  disp_collect_320_if ob ();

`ifdef DISP_STATS_EN
  logic [16:0] stat_bad_cnt;
  logic        stat_strobe;
`endif

  disp_collect_320 dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .argmin_en  (argmin_en),
    .cost       (cost),
    .disp       (disp),
    .cfg_thresh (cfg_thresh),
    .out        (ob)
`ifdef DISP_STATS_EN
    ,
    .stat_bad_cnt (stat_bad_cnt),
    .stat_strobe  (stat_strobe)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0] col;
    logic [7:0] row;
    logic [6:0] d;
    logic       c;
    logic       sl;
    logic       el;
    logic       sf;
    logic       ef;
  } exp_t;

  exp_t        q[$];
  int          sq[$];
  int          tests = 0;
  int          fails = 0;
  int          pcol = 0;
  int          prow = 0;
  int          sbad = 0;
  logic        en_s = 1'b1;
  logic [6:0]  s_cost = '0;
  logic [6:0]  s_disp = '0;
  logic [6:0]  pc [7];
  logic [6:0]  pd [7];

  assign cost = pc[6];
  assign disp = pd[6];

  always @(negedge clk) en_s = argmin_en;

  // upstream tree: data advances only on en-qualified edges
  always @(posedge clk) begin
    if (en_s) begin
      pc[0] <= s_cost;
      pd[0] <= s_disp;
      for (int i = 1; i < 7; i++) begin
        pc[i] <= pc[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  // expected word computed when the pixel is accepted
  always @(posedge clk) begin
    exp_t e;
    if (rst && en_s && in_valid) begin
      e.col = 9'(pcol);
      e.row = 8'(prow);
      e.c   = (s_cost <= cfg_thresh) && (pcol >= 79);
      e.d   = e.c ? s_disp : 7'd0;
      e.sl  = (pcol == 0);
      e.el  = (pcol == 319);
      e.sf  = (pcol == 0) && (prow == 0);
      e.ef  = (pcol == 319) && (prow == 239);
      q.push_back(e);
      sbad += e.c ? 0 : 1;
      if (e.ef) begin
        sq.push_back(sbad);
        sbad = 0;
      end
      if (pcol == 319) begin
        pcol = 0;
        prow = (prow == 239) ? 0 : prow + 1;
      end else begin
        pcol++;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst && ob.out_valid && ob.out_ready) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL extra_word got d=%0d c=%0b, required none",
                 ob.out_disp, ob.out_conf);
      end else begin
        e = q.pop_front();
        if ({ob.out_disp, ob.out_conf, ob.out_sol, ob.out_eol,
             ob.out_sof, ob.out_eof} !==
            {e.d, e.c, e.sl, e.el, e.sf, e.ef}) begin
          fails++;
          $display("FAIL word(%0d,%0d) got d=%0d c/sl/el/sf/ef=%b, required d=%0d %b",
                   e.col, e.row, ob.out_disp,
                   {ob.out_conf, ob.out_sol, ob.out_eol, ob.out_sof, ob.out_eof},
                   e.d, {e.c, e.sl, e.el, e.sf, e.ef});
        end
      end
    end
  end

`ifdef DISP_STATS_EN
  always @(negedge clk) begin
    int s;
    if (rst && stat_strobe) begin
      tests++;
      s = (sq.size() != 0) ? sq.pop_front() : -1;
      if (int'(stat_bad_cnt) != s) begin
        fails++;
        $display("FAIL stat_bad_cnt got %0d, required %0d", stat_bad_cnt, s);
      end
    end
  end
`endif

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic drive_px(input logic v, input logic [6:0] c);
    logic ok;
    int   n;
    in_valid = v;
    s_cost   = c;
    s_disp   = 7'(pcol % 80);
    n = 0;
    do begin
      @(posedge clk);
      ok = en_s;
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) begin
      fails++;
      tests++;
      $display("FAIL accept_timeout got en=0, required en=1");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    ob.out_ready = 1'b1;
    in_valid = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", q.size(), 0);
  endtask

  initial begin
    int lat;
    ob.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      pc[i] = '0;
      pd[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(ob.out_valid), 0);
    chk("rst_argmin_en", int'(argmin_en), 1);
    chk("rst_out_disp", int'(ob.out_disp), 0);
    chk("rst_markers", int'({ob.out_conf, ob.out_sol, ob.out_eol,
                             ob.out_sof, ob.out_eof}), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    lat = 0;
    fork
      for (int i = 0; i < 320; i++) drive_px(1'b1, 7'd5);
      begin
        for (int k = 1; k <= 20; k++) begin
          @(posedge clk);
          #1;
          if (ob.out_valid && lat == 0) lat = k;
        end
      end
    join
    chk("first_latency", lat, 8);

    for (int i = 0; i < 100; i++) drive_px(1'b1, (i % 2) ? 7'd21 : 7'd20);

    fork
      begin
        ob.out_ready = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("stall_en_low", int'(argmin_en), 0);
        chk("stall_full_valid", int'(ob.out_valid), 1);
        ob.out_ready = 1'b1;
      end
      for (int i = 0; i < 40; i++) drive_px(1'b1, 7'd3);
    join

    drain();
    drive_px(1'b1, 7'd4);
    drive_px(1'b0, 7'd4);
    drive_px(1'b0, 7'd4);
    drive_px(1'b1, 7'd4);
    chk("bubble_words", q.size(), 2);
    drain();

    while (!(pcol == 0 && prow == 0)) drive_px(1'b1, 7'd5);
    for (int i = 0; i < 3; i++) drive_px(1'b1, 7'd5);
    drain();

    ob.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) drive_px(1'b1, 7'd5);
    drive_px(1'b0, 7'd5);
    drive_px(1'b0, 7'd5);
    chk("pre_rst_valid", int'(ob.out_valid), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", int'(ob.out_valid), 0);
    chk("mid_rst_en", int'(argmin_en), 1);
    q.delete();
    sq.delete();
    pcol = 0;
    prow = 0;
    sbad = 0;
`ifdef DISP_STATS_EN
    chk("mid_rst_stat", int'(stat_bad_cnt), 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;
    ob.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_idle", int'(ob.out_valid), 0);
    for (int i = 0; i < 5; i++) drive_px(1'b1, 7'd5);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/disp_collect_320.md
Name: disp_collect_320

Overview:
Downstream stage of the 80-disparity argmin tree in the census_fifo_320 stereo pipeline. It keeps the argmin data path tagged: it tracks which pipeline slots carry real pixels, and it stalls the tree through its en input under back-pressure. Each winning disparity is tagged with a column and row position and with a confidence flag (cost threshold plus left-border mask). Results are buffered in a small FIFO and leave on a valid/ready stream with line and frame markers.

Parameters:
COST_WIDTH, 7, width of the minimum-cost word from the argmin tree
DISP_WIDTH, 7, width of the disparity index (clog2 of NUM_DISP)
NUM_DISP, 80, disparity search range
IMG_WIDTH, 320, pixels per line
IMG_HEIGHT, 240, lines per frame
PIPE_LAT, 7, argmin pipeline depth in en-qualified cycles
FIFO_DEPTH, 8, output FIFO entries (power of two, at least 2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  upstream presents a real cost vector to the argmin tree this cycle (sampled only when argmin_en=1)
argmin_en  out  1  drives en of the argmin tree and the upstream cost generator
cost  in  COST_WIDTH  argmin minimum cost (outp)
disp  in  DISP_WIDTH  argmin index (outp_addr)
cfg_thresh  in  COST_WIDTH  maximum accepted cost; quasi-static, changed only between frames
out_valid  out  1  output word available
out_ready  in  1  consumer accepts the word
out_disp  out  DISP_WIDTH  disparity; 0 when out_conf=0
out_conf  out  1  disparity is trustworthy
out_sol / out_eol  out  1  first / last pixel of a line
out_sof / out_eof  out  1  first / last pixel of a frame

Behaviour:
- Reset state (rst=0, asynchronous):
  - valid tag chain, col, row and FIFO pointers/count cleared
  - out_valid=0; out_disp, out_conf and all markers 0
  - argmin_en=1
  - Reset asserted mid-frame discards all in-flight tags and buffered words; the next accepted pixel is frame position (0,0).
- argmin_en = !fifo_full, decoded from the registered count with no combinational path from out_ready.
  - Consequence: at most one capture per cycle, and nothing leaves the tree while en=0, so no word is ever lost.
- Tag chain vld[0..PIPE_LAT-1] advances only on edges where argmin_en=1; vld[0] <= in_valid.
  - When argmin_en=0 the chain holds, mirroring the tree's registers.
- Capture happens on an edge where argmin_en=1 and vld[PIPE_LAT-1]=1. cost/disp are sampled on that edge.
  - vld tail=1 with en=0 must not capture; the word is held for a later edge, never pushed twice.
- Position counters:
  - col increments per capture and wraps IMG_WIDTH-1 -> 0.
  - row increments on col wrap and wraps IMG_HEIGHT-1 -> 0.
- Per captured word:
  - conf = (cost <= cfg_thresh) && (col >= NUM_DISP-1); the comparison is unsigned.
  - out_disp = conf ? disp : 0.
  - sol = (col==0); eol = (col==IMG_WIDTH-1).
  - sof = sol && row==0; eof = eol && row==IMG_HEIGHT-1.
- FIFO:
  - Synchronous, first-word registered. A captured word is visible on out_valid the cycle after the capture edge.
  - Pop happens on an edge with out_valid && out_ready.
  - Simultaneous push and pop when full is impossible, because en=0 when full. Simultaneous push and pop when non-full leaves the count unchanged.
  - Outputs are stable while out_valid=1 && out_ready=0.
- Minimum end-to-end latency, in_valid accepted to out_valid: PIPE_LAT+1 cycles with en continuously high.

Optional Feature:
Macro DISP_STATS_EN.
- Defined:
  - Adds outputs stat_bad_cnt [clog2(IMG_WIDTH*IMG_HEIGHT+1)-1:0] and stat_strobe (1 bit).
  - An internal counter increments per captured word with conf=0.
  - On capture of an eof word, stat_bad_cnt is loaded with the frame total (including that word) and stat_strobe pulses for one cycle. The internal counter then clears for the next frame.
  - All stats registers reset to 0.
- Undefined: the ports and logic are absent, and all other behaviour is identical.

Test Plan:
- Reset release, out_ready=1, in_valid=1 continuously, cost=5, cfg_thresh=20, disp=col mod 80 -> first out_valid 8 cycles after first accepted input; words 0..78 have conf=0, disp=0; word 79 has conf=1, disp=79; out_sol on word 0; out_eol on word 319.
- Mid-line, cost toggling 20/21 with cfg_thresh=20 -> conf alternates 1/0; the conf=0 word carries out_disp=0.
- out_ready=0 for 30 cycles during streaming -> argmin_en falls once 8 words are buffered; tag chain frozen; after release, the words come out in order with no gap, duplicate or loss, checked by column sequence.
- Bubbles: in_valid pattern 1,0,0,1 -> exactly two output words, columns consecutive, no extra captures.
- Full frame, 76800 pixels -> out_sof only on (0,0), out_eof only on (319,239); the next pixel is out_sof with col=0, row=0.
- rst pulsed low for 1 cycle with 5 tags in flight and 3 buffered words -> out_valid=0 immediately; the next output is out_sof; with DISP_STATS_EN, stat_bad_cnt=0 and stat_strobe after eof of an all-low-cost frame reports 79*240=18960.
